// File: rtl/core_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Package     : core_pkg                                                     |
// | Description : Shared constants, multiply FSM state type and a small        |
// |               address helper for the hazard controller.                    |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
package core_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int NUM_REGS   = 32;
  // Wide enough for MUL_LAT-1 with MUL_LAT up to 15.
  localparam int MUL_CNT_W  = 4;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    BUSY = 1'b1
  } mul_state_e;

  // x0 is hardwired to zero and never tracked.
  function automatic logic addr_nz(input logic [REG_ADDR_W-1:0] addr);
    return addr != '0;
  endfunction

endpackage
`default_nettype wire

// File: rtl/hazard_scoreboard.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : hazard_scoreboard                                            |
// | Description : Per-register pending/long-latency bits for x1..x31.          |
// |               One set port (issue), one clear port (writeback), two       |
// |               source read ports and a destination read port.              |
// |               Read ports return the write-first effective pending bit.    |
// | Ports       : clk_i, rsn_i            clock, sync active-low reset         |
// |               set_en_i/addr/long_i    mark register pending on issue       |
// |               clr_en_i/clr_addr_i     clear register on writeback          |
// |               rs1/rs2/rd_addr_i       read addresses                       |
// |               rs*_pend_o, rs*_long_o  effective pending / long producer    |
// |               rd_pend_o               effective pending of destination     |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module hazard_scoreboard
  import core_pkg::*;
(
  input  logic                  clk_i,
  input  logic                  rsn_i,
  input  logic                  set_en_i,
  input  logic [REG_ADDR_W-1:0] set_addr_i,
  input  logic                  set_long_i,
  input  logic                  clr_en_i,
  input  logic [REG_ADDR_W-1:0] clr_addr_i,
  input  logic [REG_ADDR_W-1:0] rs1_addr_i,
  input  logic [REG_ADDR_W-1:0] rs2_addr_i,
  input  logic [REG_ADDR_W-1:0] rd_addr_i,
  output logic                  rs1_pend_o,
  output logic                  rs1_long_o,
  output logic                  rs2_pend_o,
  output logic                  rs2_long_o,
  output logic                  rd_pend_o
);

  logic [NUM_REGS-1:1] pend_q, pend_d;
  logic [NUM_REGS-1:1] long_q, long_d;
  logic [NUM_REGS-1:0] eff_pend;
  logic [NUM_REGS-1:0] long_full;

  // A set in the same cycle as a clear of the same register wins: the
  // newly issued producer has not written back yet.
  always_comb begin
    pend_d = pend_q;
    long_d = long_q;
    for (int r = 1; r < NUM_REGS; r++) begin
      if (set_en_i && (set_addr_i == REG_ADDR_W'(r))) begin
        pend_d[r] = 1'b1;
        long_d[r] = set_long_i;
      end else if (clr_en_i && (clr_addr_i == REG_ADDR_W'(r))) begin
        pend_d[r] = 1'b0;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rsn_i) begin
      pend_q <= '0;
      long_q <= '0;
    end else begin
      pend_q <= pend_d;
      long_q <= long_d;
    end
  end

  // Register file is write-first: a register written back this cycle is
  // already readable, so it is masked out of the hazard view.
  assign eff_pend[0] = 1'b0;
  generate
    for (genvar r = 1; r < NUM_REGS; r++) begin : g_eff
      assign eff_pend[r] = pend_q[r] & ~(clr_en_i && (clr_addr_i == REG_ADDR_W'(r)));
    end
  endgenerate

  assign long_full = {long_q, 1'b0};

  assign rs1_pend_o = eff_pend[rs1_addr_i];
  assign rs1_long_o = long_full[rs1_addr_i];
  assign rs2_pend_o = eff_pend[rs2_addr_i];
  assign rs2_long_o = long_full[rs2_addr_i];
  assign rd_pend_o  = eff_pend[rd_addr_i];

endmodule
`default_nettype wire

// File: rtl/hazard_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : hazard_ctrl                                                  |
// | Description : Pipeline hazard controller. Stalls decode on RAW/WAW         |
// |               hazards against in-flight writes, sequences multi-cycle     |
// |               multiplies, and turns branch resolution and data-memory     |
// |               back-pressure into kill/stall for all stage latches.        |
// | Config      : HAZARD_FWD_EN - when defined, an execute->decode bypass     |
// |               exists and only long-latency producers (load/mul) cause a   |
// |               source hazard. Undefined: any pending source stalls.        |
// | Ports       : clk_i, rsn_i           clock, sync active-low reset          |
// |               dec_*_i                decode instruction fields             |
// |               exe_branch_taken_i     taken branch/jump in execute          |
// |               mem_ready_i            data memory ready                     |
// |               wb_*_i                 writeback register write              |
// |               stall_core_o, kill_o   stage latch controls                  |
// |               mul_busy_o             multiply in progress                  |
// | Parameter   : MUL_LAT multiply latency incl. issue cycle, 2..15            |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module hazard_ctrl
  import core_pkg::*;
#(
  parameter int unsigned MUL_LAT = 4
) (
  input  logic                  clk_i,
  input  logic                  rsn_i,
  input  logic                  dec_valid_i,
  input  logic [REG_ADDR_W-1:0] dec_rs1_addr_i,
  input  logic                  dec_rs1_used_i,
  input  logic [REG_ADDR_W-1:0] dec_rs2_addr_i,
  input  logic                  dec_rs2_used_i,
  input  logic [REG_ADDR_W-1:0] dec_write_addr_i,
  input  logic                  dec_int_write_enable_i,
  input  logic                  dec_is_load_i,
  input  logic                  dec_is_mul_i,
  input  logic                  exe_branch_taken_i,
  input  logic                  mem_ready_i,
  input  logic [REG_ADDR_W-1:0] wb_write_addr_i,
  input  logic                  wb_int_write_enable_i,
  output logic                  stall_core_o,
  output logic                  kill_o,
  output logic                  mul_busy_o
);

  mul_state_e           state_q, state_d;
  logic [MUL_CNT_W-1:0] cnt_q, cnt_d;

  logic rs1_pend, rs1_long;
  logic rs2_pend, rs2_long;
  logic rd_pend;
  logic rs1_qual, rs2_qual;
  logic hazard;
  logic issue;
  logic sb_set_en;

  hazard_scoreboard u_scoreboard (
    .clk_i      (clk_i),
    .rsn_i      (rsn_i),
    .set_en_i   (sb_set_en),
    .set_addr_i (dec_write_addr_i),
    .set_long_i (dec_is_load_i | dec_is_mul_i),
    .clr_en_i   (wb_int_write_enable_i),
    .clr_addr_i (wb_write_addr_i),
    .rs1_addr_i (dec_rs1_addr_i),
    .rs2_addr_i (dec_rs2_addr_i),
    .rd_addr_i  (dec_write_addr_i),
    .rs1_pend_o (rs1_pend),
    .rs1_long_o (rs1_long),
    .rs2_pend_o (rs2_pend),
    .rs2_long_o (rs2_long),
    .rd_pend_o  (rd_pend)
  );

`ifdef HAZARD_FWD_EN
  // ALU results are bypassed from execute, only load/mul results are late.
  assign rs1_qual = rs1_pend & rs1_long;
  assign rs2_qual = rs2_pend & rs2_long;
`else
  assign rs1_qual = rs1_pend;
  assign rs2_qual = rs2_pend;
  logic unused_long;
  assign unused_long = rs1_long ^ rs2_long;
`endif

  assign hazard = dec_valid_i & (
                    (dec_rs1_used_i & rs1_qual) |
                    (dec_rs2_used_i & rs2_qual) |
                    (dec_int_write_enable_i & addr_nz(dec_write_addr_i) & rd_pend));

  assign mul_busy_o = (state_q == BUSY);

  // Execute holds the multiply while busy, so a branch flag there is stale.
  assign kill_o       = ~rsn_i | (exe_branch_taken_i & ~mul_busy_o);
  assign stall_core_o = ~kill_o & (hazard | mul_busy_o | ~mem_ready_i);
  assign issue        = dec_valid_i & ~stall_core_o & ~kill_o;

  assign sb_set_en = issue & dec_int_write_enable_i & addr_nz(dec_write_addr_i);

  // Multiply sequencer: cnt starts at MUL_LAT-1 and the FSM leaves BUSY
  // on the edge after cnt reaches 1, giving MUL_LAT-1 busy cycles.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (issue && dec_is_mul_i) begin
          state_d = BUSY;
          cnt_d   = MUL_CNT_W'(MUL_LAT - 1);
        end
      end
      BUSY: begin
        cnt_d = cnt_q - MUL_CNT_W'(1);
        if (cnt_q == MUL_CNT_W'(1)) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rsn_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_hazard_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_hazard_ctrl                                               |
// | Description : Scoreboard bench for hazard_ctrl. A driver issues directed  |
// |               and random decode/execute/writeback stimulus, predicts      |
// |               outputs from a register-level reference model and queues    |
// |               them; a monitor pops and compares every cycle.              |
// | Config      : honours HAZARD_FWD_EN in the reference model                 |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_hazard_ctrl;

  localparam int MUL_LAT = 4;

  typedef struct {
    logic       rsn;
    logic       valid;
    logic [4:0] rs1;
    logic       u1;
    logic [4:0] rs2;
    logic       u2;
    logic [4:0] rd;
    logic       we;
    logic       ld;
    logic       mul;
    logic       br;
    logic       mrdy;
    logic [4:0] wba;
    logic       wbe;
  } stim_t;

  typedef struct {
    int   cyc;
    logic stall;
    logic kill;
    logic busy;
    logic chk_busy;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rsn_i = 1'b0, dec_valid_i = 1'b0;
  logic [4:0] dec_rs1_addr_i = '0, dec_rs2_addr_i = '0, dec_write_addr_i = '0;
  logic       dec_rs1_used_i = 1'b0, dec_rs2_used_i = 1'b0;
  logic       dec_int_write_enable_i = 1'b0, dec_is_load_i = 1'b0, dec_is_mul_i = 1'b0;
  logic       exe_branch_taken_i = 1'b0, mem_ready_i = 1'b1;
  logic [4:0] wb_write_addr_i = '0;
  logic       wb_int_write_enable_i = 1'b0;
  logic       stall_core_o, kill_o, mul_busy_o;

  hazard_ctrl #(.MUL_LAT(MUL_LAT)) dut (
    .clk_i                  (clk),
    .rsn_i                  (rsn_i),
    .dec_valid_i            (dec_valid_i),
    .dec_rs1_addr_i         (dec_rs1_addr_i),
    .dec_rs1_used_i         (dec_rs1_used_i),
    .dec_rs2_addr_i         (dec_rs2_addr_i),
    .dec_rs2_used_i         (dec_rs2_used_i),
    .dec_write_addr_i       (dec_write_addr_i),
    .dec_int_write_enable_i (dec_int_write_enable_i),
    .dec_is_load_i          (dec_is_load_i),
    .dec_is_mul_i           (dec_is_mul_i),
    .exe_branch_taken_i     (exe_branch_taken_i),
    .mem_ready_i            (mem_ready_i),
    .wb_write_addr_i        (wb_write_addr_i),
    .wb_int_write_enable_i  (wb_int_write_enable_i),
    .stall_core_o           (stall_core_o),
    .kill_o                 (kill_o),
    .mul_busy_o             (mul_busy_o)
  );

  // Reference model: which registers await a result, which of those come
  // from a long-latency unit, and how many multiply stall cycles remain.
  bit    pend [32];
  bit    lng  [32];
  int    mul_left = 0;
  stim_t prev_s;
  bit    prev_issue = 0;
  bit    have_prev  = 0;
  int    cyc        = 0;

  exp_t  expq [$];
  int    compared   = 0;
  int    mismatched = 0;
  bit    drv_done   = 0;

  function automatic bit eff_pend(input stim_t s, input logic [4:0] r);
    return (r != 0) && pend[r] && !(s.wbe && s.wba == r);
  endfunction

  function automatic bit src_hazard(input stim_t s, input logic [4:0] r);
`ifdef HAZARD_FWD_EN
    return eff_pend(s, r) && lng[r];
`else
    return eff_pend(s, r);
`endif
  endfunction

  // Apply what happened at the clock edge that just passed.
  task automatic model_edge();
    if (!have_prev) return;
    if (!prev_s.rsn) begin
      foreach (pend[r]) begin pend[r] = 0; lng[r] = 0; end
      mul_left = 0;
    end else begin
      if (prev_s.wbe && prev_s.wba != 0) pend[prev_s.wba] = 0;
      if (prev_issue && prev_s.we && prev_s.rd != 0) begin
        pend[prev_s.rd] = 1;
        lng[prev_s.rd]  = prev_s.ld | prev_s.mul;
      end
      if (mul_left > 0) mul_left--;
      else if (prev_issue && prev_s.mul) mul_left = MUL_LAT - 1;
    end
  endtask

  task automatic step(input stim_t s);
    exp_t e;
    bit   busy, kill, hz, stall;
    @(posedge clk);
    #1;
    model_edge();
    rsn_i = s.rsn; dec_valid_i = s.valid;
    dec_rs1_addr_i = s.rs1; dec_rs1_used_i = s.u1;
    dec_rs2_addr_i = s.rs2; dec_rs2_used_i = s.u2;
    dec_write_addr_i = s.rd; dec_int_write_enable_i = s.we;
    dec_is_load_i = s.ld; dec_is_mul_i = s.mul;
    exe_branch_taken_i = s.br; mem_ready_i = s.mrdy;
    wb_write_addr_i = s.wba; wb_int_write_enable_i = s.wbe;

    busy  = (mul_left > 0);
    kill  = !s.rsn || (s.br && !busy);
    hz    = s.valid && ((s.u1 && src_hazard(s, s.rs1)) ||
                        (s.u2 && src_hazard(s, s.rs2)) ||
                        (s.we && eff_pend(s, s.rd)));
    stall = !kill && (hz || busy || !s.mrdy);
    e.cyc = cyc; e.stall = stall; e.kill = kill; e.busy = busy;
    e.chk_busy = have_prev;  // FSM state is undefined before the first edge
    expq.push_back(e);
    prev_s = s; prev_issue = s.valid && !stall && !kill; have_prev = 1;
    cyc++;
  endtask

  function automatic stim_t nop();
    stim_t s;
    s.rsn = 1; s.valid = 0; s.rs1 = 0; s.u1 = 0; s.rs2 = 0; s.u2 = 0;
    s.rd = 0; s.we = 0; s.ld = 0; s.mul = 0; s.br = 0; s.mrdy = 1;
    s.wba = 0; s.wbe = 0;
    return s;
  endfunction

  function automatic stim_t wr(input logic [4:0] rd, input bit ld, input bit mul);
    stim_t s = nop();
    s.valid = 1; s.rd = rd; s.we = 1; s.ld = ld; s.mul = mul;
    return s;
  endfunction

  function automatic stim_t rd_src(input logic [4:0] r1, input logic [4:0] r2);
    stim_t s = nop();
    s.valid = 1; s.rs1 = r1; s.u1 = (r1 != 0); s.rs2 = r2; s.u2 = (r2 != 0);
    return s;
  endfunction

  function automatic stim_t rnd();
    stim_t s;
    int    k;
    s.rsn   = ($urandom_range(0, 99) != 0);
    s.valid = ($urandom_range(0, 9) < 8);
    s.rs1   = 5'($urandom_range(0, 7)); s.u1 = 1'($urandom);
    s.rs2   = 5'($urandom_range(0, 7)); s.u2 = 1'($urandom);
    s.rd    = 5'($urandom_range(0, 7)); s.we = ($urandom_range(0, 9) < 7);
    k       = $urandom_range(0, 9);
    s.ld    = (k < 2); s.mul = (k == 2);
    s.br    = ($urandom_range(0, 99) < 8);
    s.mrdy  = ($urandom_range(0, 9) != 0);
    s.wbe   = ($urandom_range(0, 9) < 4);
    s.wba   = 5'($urandom_range(0, 7));
    return s;
  endfunction

  task automatic check(input string name, input int c, input logic act, input logic req);
    compared++;
    if (act !== req) begin
      mismatched++;
      $display("FAIL %s cycle %0d: got %b, required %b", name, c, act, req);
    end
  endtask

  // Monitor: outputs are valid every cycle, sampled mid-cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (expq.size() > 0) begin
        e = expq.pop_front();
        check("kill_o", e.cyc, kill_o, e.kill);
        check("stall_core_o", e.cyc, stall_core_o, e.stall);
        if (e.chk_busy) check("mul_busy_o", e.cyc, mul_busy_o, e.busy);
      end
    end
  end

  // Driver
  initial begin
    stim_t s;
    // Reset for two cycles.
    s = nop(); s.rsn = 0;
    repeat (2) step(s);
    step(nop());

    // RAW on a load to x5: stall until writeback of x5, release that cycle.
    step(wr(5, 1, 0));
    repeat (3) step(rd_src(5, 0));
    s = rd_src(5, 0); s.wbe = 1; s.wba = 5; step(s);
    step(nop());

    // RAW on a single-cycle ALU op to x7.
    step(wr(7, 0, 0));
    repeat (2) step(rd_src(0, 7));
    s = rd_src(0, 7); s.wbe = 1; s.wba = 7; step(s);
    step(nop());

    // Multiply to x9, branch pulse during busy must not kill.
    step(wr(9, 0, 1));
    step(rd_src(1, 2));
    s = rd_src(1, 2); s.br = 1; step(s);
    step(rd_src(1, 2));
    step(rd_src(1, 2));
    s = nop(); s.wbe = 1; s.wba = 9; step(s);

    // Branch kill with a hazard present; killed rd x10 must stay clear.
    step(wr(6, 1, 0));
    s = rd_src(6, 0); s.rd = 10; s.we = 1; s.br = 1; step(s);
    s = wr(10, 0, 0); step(s);
    s = nop(); s.wbe = 1; s.wba = 6; step(s);
    s = nop(); s.wbe = 1; s.wba = 10; step(s);

    // Writeback clears x3 while a new write to x3 issues: set wins.
    step(wr(3, 1, 0));
    s = wr(3, 1, 0); s.wbe = 1; s.wba = 3; step(s);
    repeat (2) step(rd_src(3, 0));
    s = rd_src(3, 0); s.wbe = 1; s.wba = 3; step(s);

    // Memory back-pressure.
    s = nop(); s.mrdy = 0; step(s);
    s = rd_src(1, 1); s.mrdy = 0; step(s);
    step(nop());

    // Randomised traffic.
    for (int i = 0; i < 3000; i++) step(rnd());

    @(posedge clk);
    repeat (2) @(negedge clk);
    drv_done = 1;
  end

  initial begin
    fork
      wait (drv_done);
      #200000;
    join_any
    if (!drv_done) begin
      mismatched++;
      $display("FAIL watchdog: run incomplete at time %0t, required completion", $time);
    end
    if (expq.size() != 0) begin
      mismatched++;
      $display("FAIL drain: %0d expectations left, required 0", expq.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
`default_nettype wire
